// File: rtl/pe_link_pkg.sv
// pe_link_pkg: shared link geometry, bit positions and link-word type for the PE link tx/rx pair
package pe_link_pkg;
  localparam int AXIS_WIDTH = 128;
  localparam int LINK_WIDTH = AXIS_WIDTH + 2;
  localparam int LINK_VALID_BIT = AXIS_WIDTH;
  localparam int LINK_CREDIT_BIT = AXIS_WIDTH + 1;
  typedef struct packed {
    logic credit;
    logic valid;
    logic [AXIS_WIDTH-1:0] data;
  } link_word_t;
endpackage

// File: rtl/pe_link_tx_if.sv
// pe_link_tx_if: upstream valid/ready stream (din, val_in from master; ready_upward from slave)
interface pe_link_tx_if;
  import pe_link_pkg::*;
  logic [AXIS_WIDTH-1:0] din;
  logic val_in;
  logic ready_upward;
  modport master (output din, output val_in, input ready_upward);
  modport slave (input din, input val_in, output ready_upward);
endinterface

// File: rtl/pe_credit_counter.sv
// pe_credit_counter: saturating up/down counter (inc_i, dec_i in; cnt_o count, ovf_o sticky overflow out)
module pe_credit_counter #(
  parameter int MAX = 4,
  parameter int INIT = MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] cnt_o,
  output logic       ovf_o
);
  localparam logic [7:0] MAX8 = 8'(MAX);
  localparam logic [7:0] INIT8 = 8'(INIT);
  logic [7:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, sat_hi, sat_lo;
  always_comb begin
    sat_hi = inc_i & ~dec_i & (cnt_q == MAX8);
    sat_lo = dec_i & ~inc_i & (cnt_q == 8'd0);
    cnt_d = (sat_hi | sat_lo) ? cnt_q : cnt_q + 8'(inc_i) - 8'(dec_i);
    ovf_d = ovf_q | sat_hi;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= INIT8;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/pe_link_tx.sv
// pe_link_tx: credit-based link transmitter (up stream in; link_out/link_in link; credit_ret in; credit_cnt, tx_words, err_credit_ovf status out)
module pe_link_tx
  import pe_link_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  pe_link_tx_if.slave           up,
  output logic [LINK_WIDTH-1:0] link_out,
  input  logic [LINK_WIDTH-1:0] link_in,
  input  logic                  credit_ret,
  output logic [7:0]            credit_cnt,
  output logic [31:0]           tx_words,
  output logic                  err_credit_ovf
);
  link_word_t link_q, link_d;
  logic [31:0] tx_q, tx_d;
  logic fire;
  logic unused_link_in;
  assign unused_link_in = ^link_in[LINK_VALID_BIT:0];
  assign up.ready_upward = ap_start & (credit_cnt != 8'd0);
  assign fire = up.val_in & up.ready_upward;
  pe_credit_counter #(.MAX(CREDITS)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (link_in[LINK_CREDIT_BIT]),
    .dec_i (fire),
    .cnt_o (credit_cnt),
    .ovf_o (err_credit_ovf)
  );
  always_comb begin
    link_d.data = fire ? up.din : link_q.data;
    link_d.valid = fire;
    link_d.credit = credit_ret;
    tx_d = tx_q + 32'(fire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      link_q <= '0;
      tx_q <= '0;
    end else begin
      link_q <= link_d;
      tx_q <= tx_d;
    end
  end
  assign link_out = link_q;
  assign tx_words = tx_q;
endmodule

// File: tb/tb_pe_link_tx.sv
// tb_pe_link_tx: directed self-checking bench for pe_link_tx
module tb_pe_link_tx;
  logic clk = 1'b0;
  logic reset, ap_start, credit_ret;
  logic [129:0] link_out, link_in;
  logic [7:0] credit_cnt;
  logic [31:0] tx_words;
  logic err_credit_ovf;
  int checks = 0;
  int errors = 0;
  pe_link_tx_if up ();
  pe_link_tx #(.CREDITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ap_start       (ap_start),
    .up             (up.slave),
    .link_out       (link_out),
    .link_in        (link_in),
    .credit_ret     (credit_ret),
    .credit_cnt     (credit_cnt),
    .tx_words       (tx_words),
    .err_credit_ovf (err_credit_ovf)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [129:0] word(input logic cr, input logic v, input logic [127:0] d);
    return {cr, v, d};
  endfunction
  initial begin
    reset = 1'b1; ap_start = 1'b1; credit_ret = 1'b0; link_in = '0;
    up.din = '0; up.val_in = 1'b0;
    cyc(); cyc();
    chk("rst_cnt", 130'(credit_cnt), 130'd4);
    chk("rst_link", link_out, '0);
    chk("rst_tx", 130'(tx_words), '0);
    chk("rst_ovf", 130'(err_credit_ovf), '0);
    chk("rst_ready", 130'(up.ready_upward), 130'd1);
    reset = 1'b0;
    up.val_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up.din = 128'(i);
      cyc();
      chk("burst_link", link_out, word(1'b0, 1'b1, 128'(i)));
      chk("burst_cnt", 130'(credit_cnt), 130'(4 - i));
    end
    up.din = 128'd5;
    #1;
    chk("stall_ready", 130'(up.ready_upward), '0);
    cyc();
    chk("stall_link", link_out, word(1'b0, 1'b0, 128'd4));
    chk("stall_cnt", 130'(credit_cnt), '0);
    chk("stall_tx", 130'(tx_words), 130'd4);
    link_in[129] = 1'b1;
    cyc();
    chk("cr1_cnt", 130'(credit_cnt), 130'd1);
    chk("cr1_link", link_out, word(1'b0, 1'b0, 128'd4));
    chk("cr1_ready", 130'(up.ready_upward), 130'd1);
    cyc();
    chk("cr2_link", link_out, word(1'b0, 1'b1, 128'd5));
    chk("cr2_cnt", 130'(credit_cnt), 130'd1);
    link_in[129] = 1'b0;
    up.din = 128'd6;
    cyc();
    chk("cr3_link", link_out, word(1'b0, 1'b1, 128'd6));
    chk("cr3_cnt", 130'(credit_cnt), '0);
    chk("cr3_tx", 130'(tx_words), 130'd6);
    up.val_in = 1'b0;
    link_in[129] = 1'b1;
    cyc(); cyc();
    chk("pre_sim_cnt", 130'(credit_cnt), 130'd2);
    up.val_in = 1'b1;
    up.din = 128'd7;
    cyc();
    chk("sim_cnt", 130'(credit_cnt), 130'd2);
    chk("sim_link", link_out, word(1'b0, 1'b1, 128'd7));
    up.val_in = 1'b0;
    cyc();
    chk("ovf_cnt3", 130'(credit_cnt), 130'd3);
    cyc();
    chk("ovf_cnt4", 130'(credit_cnt), 130'd4);
    chk("ovf_pre", 130'(err_credit_ovf), '0);
    cyc();
    chk("ovf_cnt_hold", 130'(credit_cnt), 130'd4);
    chk("ovf_flag", 130'(err_credit_ovf), 130'd1);
    link_in[129] = 1'b0;
    ap_start = 1'b0;
    up.val_in = 1'b1;
    up.din = 128'hDEAD;
    #1;
    chk("dis_ready", 130'(up.ready_upward), '0);
    for (int i = 0; i < 3; i++) begin
      credit_ret = 1'b1;
      cyc();
      chk("fwd_pulse", link_out, word(1'b1, 1'b0, 128'd7));
      credit_ret = 1'b0;
      cyc();
      chk("fwd_gap", link_out, word(1'b0, 1'b0, 128'd7));
    end
    chk("dis_tx", 130'(tx_words), 130'd7);
    chk("dis_cnt", 130'(credit_cnt), 130'd4);
    ap_start = 1'b1;
    for (int i = 8; i <= 10; i++) begin
      up.din = 128'(i);
      cyc();
    end
    chk("mid_cnt", 130'(credit_cnt), 130'd1);
    chk("mid_link", link_out, word(1'b0, 1'b1, 128'd10));
    up.din = 128'd11;
    reset = 1'b1;
    cyc();
    chk("mrst_link", link_out, '0);
    chk("mrst_cnt", 130'(credit_cnt), 130'd4);
    chk("mrst_tx", 130'(tx_words), '0);
    chk("mrst_ovf", 130'(err_credit_ovf), '0);
    reset = 1'b0;
    up.val_in = 1'b0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_link_tx.md
# pe_link_tx

Credit-based transmitter that drives one 130-bit inter-PE neighbour link (the `out_to_east` / `out_to_west` / `out_to_north` buses) from a 128-bit valid/ready stream. It is the sending end of the PE link protocol: it formats link words, enforces receiver buffer occupancy through credits returned on the paired inbound link, and forwards the local receiver's credit returns to the far end. One instance sits inside a PE per outgoing direction, between the PE datapath and the overlay fabric.

## Interface
- `AXIS_WIDTH`, 128, stream data width.
- `LINK_WIDTH`, 130, link word width; must equal `AXIS_WIDTH+2`.
- `CREDITS`, 4, receiver buffer depth in words at the far end; range 1..255.
- `clk`  input  1  sole clock.
- `reset`  input  1  synchronous, active-high reset.
- `ap_start`  input  1  transmit enable; when low, no new data is accepted.
- `din`  input  AXIS_WIDTH  stream data.
- `val_in`  input  1  stream valid.
- `ready_upward`  output  1  stream ready.
- `link_out`  output  LINK_WIDTH  outgoing link word, connects to `out_to_<dir>`.
- `link_in`  input  LINK_WIDTH  inbound link word from the same neighbour, connects to `in_from_<dir>`; only the credit bit is used here.
- `credit_ret`  input  1  one-cycle pulse from the local receiver: one buffer slot freed.
- `credit_cnt`  output  8  available far-end credits.
- `tx_words`  output  32  words sent since reset, wraps.
- `err_credit_ovf`  output  1  sticky: credit received while the counter was already at `CREDITS`.

## Operation
- Link word format: `[AXIS_WIDTH-1:0]` data, `[AXIS_WIDTH]` valid, `[AXIS_WIDTH+1]` credit.
- `ready_upward = ap_start & (credit_cnt != 0)`. This is combinational from registered state only and does not depend on `val_in`.
- fire = `val_in & ready_upward`.
- The credit counter starts at `CREDITS`.
  - Next value = cnt − fire + `link_in[AXIS_WIDTH+1]`.
  - Fire and credit-in in the same cycle leave it unchanged.
- Overflow: when a credit arrives with cnt==`CREDITS` and no fire, the counter holds at `CREDITS` and `err_credit_ovf` is set. It clears only on reset.
- Underflow is impossible by construction, because fire requires cnt≠0.
- The data field updates only on fire. On non-fire cycles it holds its last value and the valid bit is 0.
- The credit bit of `link_out` is `credit_ret` registered, 1 cycle delay. It is independent of `ap_start` and of data traffic, so credits still flow while transmission is disabled.
- `tx_words` increments on each fire and wraps from 2^32−1 to 0.
- Inbound `link_in` data and valid bits are ignored.

## Timing
- Reset values: `link_out`=0, `credit_cnt`=`CREDITS`, `tx_words`=0, `err_credit_ovf`=0. `ready_upward` = `ap_start` in the first cycle after reset.
- Latency is 1 cycle: a fire in cycle N produces valid=1 with that data on `link_out` in cycle N+1.
- Throughput is 1 word/cycle while credits remain.
- A credit arriving in cycle N is usable for a fire in cycle N+1.
- `ap_start` falling: `ready_upward` drops in the same cycle, and no fire occurs. A word already registered still appears on the link.
- Reset mid-operation: in-flight `link_out` content is discarded, and credits are restored to `CREDITS`. The system resets the far-end receiver in the same cycle.

## Structure
- Shared package `pe_link_pkg`:
  - bit-position constants `LINK_VALID_BIT`, `LINK_CREDIT_BIT`;
  - `LINK_WIDTH` derivation from `AXIS_WIDTH`;
  - the link-word typedef, which the matching receiver also uses.
- One sub-module, `pe_credit_counter`: saturating up/down counter with overflow flag, reused by the receiver's occupancy tracking.

## Test plan
- **Reset then idle:** after reset with `ap_start`=1 → `credit_cnt`=4, `ready_upward`=1, `link_out`=0.
- **Burst with no credits back:** 6 back-to-back words 0x1..0x6 → 4 words appear on consecutive cycles with valid=1, then `ready_upward`=0 and `credit_cnt`=0. Words 0x5 and 0x6 are held at the source.
- **Credit returns after stall:** from `credit_cnt`=0, pulse `link_in[129]` for 2 cycles → 0x5 and 0x6 sent, `tx_words`=6, counter back to 0.
- **Simultaneous events and overflow:**
  - credit-in in the same cycle as a fire at cnt=2 → cnt stays 2;
  - credit at cnt=4 with no fire → cnt stays 4 and `err_credit_ovf`=1.
- **Credit forwarding with `ap_start`=0:** pulse `credit_ret` 3 times → `link_out[129]` pulses 3 times, each 1 cycle later, with valid=0 throughout.
- **Mid-burst reset:** reset asserted for 1 cycle during a burst with cnt=1 → next cycle `link_out`=0, cnt=4, `tx_words`=0, and the error flag is cleared.
